stlc_multi: RTL and testbench

Parametrised sensor-actuated traffic-light controller for N_PH conflicting approaches. It replaces the fixed single-approach red/green/yellow loop with several additions: per-phase latched requests, round-robin phase selection, timed minimum/maximum green, fixed yellow and an all-red clearance interval. It sits between the debounced loop-detector inputs and the lamp drivers, and has one clock domain.

---
 rtl/stlc_multi.sv | 90 +++++++++
 tb/tb_stlc_multi.sv | 136 +++++++++++++
 2 files changed

// File: rtl/stlc_multi.sv
// stlc_multi: round-robin sensor-actuated traffic-light controller for N_PH conflicting phases
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (all red, phase 0, requests dropped)
//   sensor   per-phase vehicle detect, level, synchronous to clk
//   r_light  red lamp per phase
//   g_light  green lamp per phase
//   y_light  yellow lamp per phase
//   phase    index of the active (or last served) phase
module stlc_multi #(
    parameter int N_PH    = 2,
    parameter int CNT_W   = 8,
    parameter int T_AR    = 1,
    parameter int T_Y     = 3,
    parameter int T_MIN_G = 4,
    parameter int T_MAX_G = 16,
    parameter int PH_W    = $clog2(N_PH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_PH-1:0] sensor,
    output logic [N_PH-1:0] r_light,
    output logic [N_PH-1:0] g_light,
    output logic [N_PH-1:0] y_light,
    output logic [PH_W-1:0] phase
);
    typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N_PH-1:0]  req, req_nxt, dem;
    logic [PH_W-1:0]  rr, idx;
    logic             other, found, enter_g, to_y, to_ar, sat;

    always_comb begin
        dem = req | sensor;
        other = 1'b0;
        for (int j = 0; j < N_PH; j++)
            if (PH_W'(j) != phase) other = other | dem[j];
        // round-robin pick: phase+1 first, the current phase last
        rr = phase;
        idx = '0;
        found = 1'b0;
        for (int k = 1; k <= N_PH; k++) begin
            idx = PH_W'((int'(phase) + k) % N_PH);
            if (!found && dem[idx]) begin
                rr = idx;
                found = 1'b1;
            end
        end
        enter_g = state == ALL_RED && int'(cnt) >= T_AR - 1 && |dem;
        to_y = state == GREEN && int'(cnt) >= T_MIN_G - 1 && other &&
               (!sensor[phase] || int'(cnt) == T_MAX_G - 1);
        to_ar = state == YELLOW && int'(cnt) == T_Y - 1;
        sat = state == GREEN ? int'(cnt) == T_MAX_G - 1 : &cnt;
        // clearing on green entry wins over a same-edge sensor set
        for (int i = 0; i < N_PH; i++)
            req_nxt[i] = (req[i] | (sensor[i] & ~(state == GREEN && phase == PH_W'(i))))
                         & ~(enter_g && rr == PH_W'(i));
        r_light = '1;
        g_light = '0;
        y_light = '0;
        if (state == GREEN) begin
            g_light[phase] = 1'b1;
            r_light[phase] = 1'b0;
        end
        if (state == YELLOW) begin
            y_light[phase] = 1'b1;
            r_light[phase] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALL_RED;
            phase <= '0;
            cnt   <= '0;
            req   <= '0;
        end else begin
            req <= req_nxt;
            cnt <= (enter_g || to_y || to_ar) ? '0 : sat ? cnt : cnt + CNT_W'(1);
            if (enter_g) begin
                state <= GREEN;
                phase <= rr;
            end else if (to_y) state <= YELLOW;
            else if (to_ar) state <= ALL_RED;
            else if (!(state inside {ALL_RED, GREEN, YELLOW})) state <= ALL_RED;
        end
    end
endmodule

// File: tb/tb_stlc_multi.sv
// tb_stlc_multi: directed self-checking bench for stlc_multi (2-phase and 3-phase instances)
module tb_stlc_multi;
    logic       clk = 1'b0;
    logic       rn2 = 1'b0, rn3 = 1'b0;
    logic [1:0] s2 = '0, r2, g2, y2;
    logic       ph2;
    logic [2:0] s3 = '0, r3, g3, y3;
    logic [1:0] ph3;
    int         n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    stlc_multi #(.N_PH(2), .CNT_W(8), .T_AR(1), .T_Y(2), .T_MIN_G(4), .T_MAX_G(8)) u2 (
        .clk(clk), .rst_n(rn2), .sensor(s2),
        .r_light(r2), .g_light(g2), .y_light(y2), .phase(ph2));

    stlc_multi #(.N_PH(3), .CNT_W(8), .T_AR(1), .T_Y(2), .T_MIN_G(4), .T_MAX_G(8)) u3 (
        .clk(clk), .rst_n(rn3), .sensor(s3),
        .r_light(r3), .g_light(g3), .y_light(y3), .phase(ph3));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lamp2(input string tag, input logic [1:0] r, input logic [1:0] g,
                         input logic [1:0] y, input logic p);
        chk(tag, 16'({r2, g2, y2, ph2}), 16'({r, g, y, p}));
    endtask

    task automatic lamp3(input string tag, input logic [2:0] r, input logic [2:0] g,
                         input logic [2:0] y, input logic [1:0] p);
        chk(tag, 16'({r3, g3, y3, ph3}), 16'({r, g, y, p}));
    endtask

    initial begin
        // reset
        #1 lamp2("reset_async", 2'b11, 2'b00, 2'b00, 1'b0);
        step(3);
        lamp2("reset_held", 2'b11, 2'b00, 2'b00, 1'b0);
        rn2 = 1'b1;
        step(20);
        lamp2("idle_all_red", 2'b11, 2'b00, 2'b00, 1'b0);
        // single 1-cycle request, resting green
        s2 = 2'b10;
        step(1);
        s2 = 2'b00;
        lamp2("req1_green", 2'b01, 2'b10, 2'b00, 1'b1);
        step(50);
        lamp2("rest_green", 2'b01, 2'b10, 2'b00, 1'b1);
        // gap-out of a long green on competing demand
        s2 = 2'b01;
        step(1);
        s2 = 2'b00;
        lamp2("gap_y1", 2'b01, 2'b00, 2'b10, 1'b1);
        step(1);
        lamp2("gap_y2", 2'b01, 2'b00, 2'b10, 1'b1);
        step(1);
        lamp2("gap_allred", 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        lamp2("gap_green0", 2'b10, 2'b01, 2'b00, 1'b0);
        // demand from entry: green 0 lasts exactly T_MIN_G
        s2 = 2'b10;
        step(1);
        s2 = 2'b00;
        step(2);
        lamp2("min_green_last", 2'b10, 2'b01, 2'b00, 1'b0);
        step(1);
        lamp2("min_green_yel", 2'b10, 2'b00, 2'b01, 1'b0);
        step(1);
        lamp2("min_y2", 2'b10, 2'b00, 2'b01, 1'b0);
        step(1);
        lamp2("min_allred", 2'b11, 2'b00, 2'b00, 1'b0);
        step(1);
        lamp2("min_green1", 2'b01, 2'b10, 2'b00, 1'b1);
        // max-out: own sensor held, competing pulse at entry
        s2 = 2'b11;
        step(1);
        s2 = 2'b10;
        step(6);
        lamp2("max_green_last", 2'b01, 2'b10, 2'b00, 1'b1);
        step(1);
        lamp2("max_yellow", 2'b01, 2'b00, 2'b10, 1'b1);
        step(1);
        lamp2("max_y2", 2'b01, 2'b00, 2'b10, 1'b1);
        step(1);
        lamp2("max_allred", 2'b11, 2'b00, 2'b00, 1'b1);
        step(1);
        lamp2("max_green0", 2'b10, 2'b01, 2'b00, 1'b0);
        s2 = 2'b00;
        // phase 1 request pending; green 0 gaps out after 4 cycles
        step(4);
        lamp2("pre_reset_yel", 2'b10, 2'b00, 2'b01, 1'b0);
        #2 rn2 = 1'b0;
        #1 lamp2("mid_yel_reset", 2'b11, 2'b00, 2'b00, 1'b0);
        step(2);
        rn2 = 1'b1;
        step(10);
        lamp2("post_reset_idle", 2'b11, 2'b00, 2'b00, 1'b0);
        // 3-phase round robin
        rn3 = 1'b1;
        s3 = 3'b001;
        step(1);
        s3 = 3'b100;
        lamp3("rr_green0", 3'b110, 3'b001, 3'b000, 2'd0);
        step(1);
        s3 = 3'b010;
        step(1);
        s3 = 3'b000;
        step(2);
        lamp3("rr_yellow0", 3'b110, 3'b000, 3'b001, 2'd0);
        step(3);
        lamp3("rr_green1", 3'b101, 3'b010, 3'b000, 2'd1);
        step(7);
        lamp3("rr_green2", 3'b011, 3'b100, 3'b000, 2'd2);
        // from phase 0, only phase 2 pending: phase 1 skipped
        rn3 = 1'b0;
        step(2);
        lamp3("rr_reset", 3'b111, 3'b000, 3'b000, 2'd0);
        rn3 = 1'b1;
        s3 = 3'b100;
        step(1);
        s3 = 3'b000;
        lamp3("rr_skip_to2", 3'b011, 3'b100, 3'b000, 2'd2);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
